// File: rtl/toast_pkg.sv
// Shared ToastCore types and constants: the canonical NOP, the default reset PC and the IF/ID payload.
// Imported by the fetch stage, its hold buffer and the bench.
package toast_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;  // ADDI x0,x0,0
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] inst;
  } if_id_t;

endpackage

// File: rtl/toast_fetch_stage_if.sv
// Fetch-stage bundle: downstream control, IMEM port and IF/ID payload.
// Signal suffixes are from the fetch stage's point of view; master is the fetch stage itself.
interface toast_fetch_stage_if;

  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic        id_valid_o;
  logic [31:0] id_pc_o;
  logic [31:0] id_pc_plus4_o;
  logic [31:0] id_inst_o;
  logic        misalign_o;

  modport master (
    input  stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
    output imem_en_o, imem_addr_o, id_valid_o, id_pc_o, id_pc_plus4_o, id_inst_o, misalign_o
  );

  modport slave (
    output stall_i, flush_i, redirect_i, redirect_pc_i, imem_data_i,
    input  imem_en_o, imem_addr_o, id_valid_o, id_pc_o, id_pc_plus4_o, id_inst_o, misalign_o
  );

endinterface

// File: rtl/toast_fetch_stage_hold_buffer.sv
// One-entry skid holding {pc, inst} of an IMEM response that arrived while decode was stalled.
// Priority: clear, then capture, then drain; contents visible the cycle after capture.
module fetch_hold_buffer
  import toast_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        capture_i,
  input  logic        drain_i,
  input  logic        clear_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  logic        valid_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      inst_q  <= NOP_INST;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (capture_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      inst_q  <= inst_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/toast_fetch_stage.sv
// RV32I fetch stage: PC + synchronous IMEM, 2-cycle issue-to-IF/ID, stall absorbed by a one-entry hold buffer.
// TOAST_FETCH_MISALIGN_EXC_EN: misaligned redirects are dropped and flagged on misalign_o instead of being aligned.
module toast_fetch_stage
  import toast_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 10
) (
  input  logic                clk_i,
  input  logic                rst_i,
  toast_fetch_stage_if.master fe
);

  if (IMEM_AW < 1 || IMEM_AW > 30) begin : g_aw_check
    $error("IMEM_AW must lie in 1..30");
  end

  logic [31:0] pc_f_q;
  logic        rsp_pending_q;
  logic [31:0] rsp_pc_q;
  if_id_t      id_q;

  logic        take_redirect;
  logic        clear_inflight;
  logic        hold_capture;
  logic        hold_drain;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic [31:0] redirect_target;

  assign redirect_target = fe.redirect_pc_i & 32'hFFFF_FFFC;

`ifdef TOAST_FETCH_MISALIGN_EXC_EN
  logic misalign_d;
  logic misalign_q;

  assign misalign_d    = fe.redirect_i && (fe.redirect_pc_i[1:0] != 2'b00);
  assign take_redirect = fe.redirect_i && !misalign_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end

  assign fe.misalign_o = misalign_q;
`else
  assign take_redirect = fe.redirect_i;
  assign fe.misalign_o = 1'b0;
`endif

  assign clear_inflight = take_redirect || fe.flush_i;
  // A response arriving under stall is parked; it is released before the next one lands.
  assign hold_capture   = !clear_inflight && fe.stall_i && rsp_pending_q;
  assign hold_drain     = !clear_inflight && !fe.stall_i && hold_valid;

  fetch_hold_buffer u_hold (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .capture_i (hold_capture),
    .drain_i   (hold_drain),
    .clear_i   (clear_inflight),
    .pc_i      (rsp_pc_q),
    .inst_i    (fe.imem_data_i),
    .valid_o   (hold_valid),
    .pc_o      (hold_pc),
    .inst_o    (hold_inst)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_f_q        <= RESET_PC;
      rsp_pending_q <= 1'b0;
      rsp_pc_q      <= 32'h0;
      id_q          <= '{valid: 1'b0, pc: 32'h0, pc_plus4: 32'h4, inst: NOP_INST};
    end else if (take_redirect) begin
      pc_f_q        <= redirect_target;
      rsp_pending_q <= 1'b0;
      id_q.valid    <= 1'b0;
    end else if (fe.flush_i) begin
      rsp_pending_q <= 1'b0;
      id_q.valid    <= 1'b0;
    end else if (fe.stall_i) begin
      // No issue while stalled; any arriving response has gone to the hold buffer.
      rsp_pending_q <= 1'b0;
    end else begin
      pc_f_q        <= pc_f_q + 32'd4;
      rsp_pending_q <= 1'b1;
      rsp_pc_q      <= pc_f_q;
      if (hold_valid) begin
        id_q <= '{valid: 1'b1, pc: hold_pc, pc_plus4: hold_pc + 32'd4, inst: hold_inst};
      end else if (rsp_pending_q) begin
        id_q <= '{valid: 1'b1, pc: rsp_pc_q, pc_plus4: rsp_pc_q + 32'd4, inst: fe.imem_data_i};
      end else begin
        id_q.valid <= 1'b0;
      end
    end
  end

  assign fe.imem_en_o     = !rst_i && !fe.stall_i;
  assign fe.imem_addr_o   = pc_f_q;
  assign fe.id_valid_o    = id_q.valid;
  assign fe.id_pc_o       = id_q.pc;
  assign fe.id_pc_plus4_o = id_q.pc_plus4;
  assign fe.id_inst_o     = id_q.valid ? id_q.inst : NOP_INST;

endmodule

// File: tb/tb_toast_fetch_stage.sv
// Bench for toast_fetch_stage: directed scenarios, then random stall/redirect traffic checked against
// a program-order reference (each new valid IF/ID entry is the next address, redirects cost 2 bubbles).
module tb_toast_fetch_stage;
  import toast_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  toast_fetch_stage_if fi();

  toast_fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .fe    (fi)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] imem_q;
  always @(posedge clk) if (fi.imem_en_o) imem_q <= mem[fi.imem_addr_o[11:2]];
  assign fi.imem_data_i = imem_q;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference state: next program-order PC, forced bubbles, consecutive unstalled edges.
  logic [31:0] exp_pc;
  int          need_inval;
  int          clean;
  logic        prev_v;
  logic [31:0] prev_pc, prev_inst, prev_p4;

  task automatic model_reset();
    exp_pc     = 32'h0;
    need_inval = 0;
    clean      = -1;
    prev_v     = 1'b0;
    prev_pc    = 32'h0;
    prev_inst  = NOP_INST;
    prev_p4    = 32'h4;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_valid"}, 32'(fi.id_valid_o), 32'd0);
    chk({tag, "_inst"},  fi.id_inst_o,       NOP_INST);
    chk({tag, "_pc"},    fi.id_pc_o,         32'h0);
    chk({tag, "_pc4"},   fi.id_pc_plus4_o,   32'h4);
    chk({tag, "_en"},    32'(fi.imem_en_o),  32'd0);
    chk({tag, "_addr"},  fi.imem_addr_o,     32'h0);
    chk({tag, "_mis"},   32'(fi.misalign_o), 32'd0);
  endtask

  // One clock with the given controls; flush is only used while streaming steadily.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] tgt, input logic fl);
    logic taken;
    fi.stall_i       = st;
    fi.redirect_i    = rd;
    fi.redirect_pc_i = tgt;
    fi.flush_i       = fl;
    @(posedge clk);
    #1;
    fi.stall_i    = 1'b0;
    fi.redirect_i = 1'b0;
    fi.flush_i    = 1'b0;
    taken = rd;
`ifdef TOAST_FETCH_MISALIGN_EXC_EN
    if (rd && tgt[1:0] != 2'b00) taken = 1'b0;
    chk("misalign", 32'(fi.misalign_o), 32'(rd && tgt[1:0] != 2'b00));
`else
    chk("misalign", 32'(fi.misalign_o), 32'd0);
`endif
    if (taken) begin
      exp_pc = tgt & 32'hFFFF_FFFC;
      need_inval = 2;
      clean = 0;
    end else if (fl) begin
      exp_pc = prev_pc + 32'd8;
      need_inval = 2;
      clean = 0;
    end else if (st) begin
      clean = 0;
      chk("stall_valid", 32'(fi.id_valid_o), 32'(prev_v));
      chk("stall_pc",    fi.id_pc_o,         prev_pc);
      chk("stall_inst",  fi.id_inst_o,       prev_inst);
      chk("stall_pc4",   fi.id_pc_plus4_o,   prev_p4);
    end else begin
      clean++;
      if (need_inval == 0) begin
        if (fi.id_valid_o) begin
          chk("order_pc",   fi.id_pc_o,       exp_pc);
          chk("order_inst", fi.id_inst_o,     mem[exp_pc[11:2]]);
          chk("order_pc4",  fi.id_pc_plus4_o, exp_pc + 32'd4);
          exp_pc = exp_pc + 32'd4;
        end else begin
          chk("idle_inst", fi.id_inst_o, NOP_INST);
        end
        if (clean >= 2) chk("no_gap", 32'(fi.id_valid_o), 32'd1);
      end
    end
    if (need_inval > 0) begin
      chk("bubble_valid", 32'(fi.id_valid_o), 32'd0);
      chk("bubble_inst",  fi.id_inst_o,       NOP_INST);
      need_inval--;
    end
    prev_v    = fi.id_valid_o;
    prev_pc   = fi.id_pc_o;
    prev_inst = fi.id_inst_o;
    prev_p4   = fi.id_pc_plus4_o;
  endtask

  task automatic wait_first(input string tag);
    int k;
    k = 0;
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    while (!fi.id_valid_o && k < 5) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0);
      k++;
    end
    chk(tag, 32'(fi.id_valid_o), 32'd1);
  endtask

  logic        r_st, r_rd;
  logic [31:0] r_tgt;

  initial begin
    fi.stall_i       = 1'b0;
    fi.flush_i       = 1'b0;
    fi.redirect_i    = 1'b0;
    fi.redirect_pc_i = 32'h0;
    rst = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h0010_0213;
    mem[1] = 32'h0020_0293;
    mem[2] = 32'h0052_0333;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Program start: 0, 4, 8 back to back.
    wait_first("start_valid");
    chk("seq0_pc", fi.id_pc_o, 32'h0);
    chk("seq0_inst", fi.id_inst_o, 32'h0010_0213);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("seq1_pc", fi.id_pc_o, 32'h4);
    chk("seq1_inst", fi.id_inst_o, 32'h0020_0293);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("seq2_pc", fi.id_pc_o, 32'h8);
    chk("seq2_inst", fi.id_inst_o, 32'h0052_0333);

    // Redirect to 0x40 while PC 8 sits in IF/ID.
    cycle(1'b0, 1'b1, 32'h40, 1'b0);
    chk("rd_b1_valid", 32'(fi.id_valid_o), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rd_b2_valid", 32'(fi.id_valid_o), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rd_tgt_valid", 32'(fi.id_valid_o), 32'd1);
    chk("rd_tgt_pc", fi.id_pc_o, 32'h40);

    // Redirect and stall together: redirect wins.
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b1, 1'b1, 32'h80, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("rdst_pc", fi.id_pc_o, 32'h80);
    chk("rdst_valid", 32'(fi.id_valid_o), 32'd1);

    // Flush with 0x8C in IF/ID and 0x90 in flight: resumes at 0x94.
    repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("flush_valid", 32'(fi.id_valid_o), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("flush_pc", fi.id_pc_o, 32'h94);

    // PC wrap through the top of the address space.
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap0_pc", fi.id_pc_o, 32'hFFFF_FFF8);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap1_pc", fi.id_pc_o, 32'hFFFF_FFFC);
    chk("wrap1_pc4", fi.id_pc_plus4_o, 32'h0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap2_pc", fi.id_pc_o, 32'h0);
    chk("wrap2_inst", fi.id_inst_o, 32'h0010_0213);

    // Misaligned redirect target 0x42.
    cycle(1'b0, 1'b1, 32'h42, 1'b0);
`ifdef TOAST_FETCH_MISALIGN_EXC_EN
    chk("mis_flag", 32'(fi.misalign_o), 32'd1);
    chk("mis_cont_pc", fi.id_pc_o, 32'h4);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_cont2_pc", fi.id_pc_o, 32'h8);
`else
    chk("mis_b1_valid", 32'(fi.id_valid_o), 32'd0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("mis_align_pc", fi.id_pc_o, 32'h40);
`endif

    // Short asynchronous reset pulse between edges.
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #2;
    check_reset("pulse");
    rst = 1'b0;
    model_reset();
    wait_first("restart_valid");
    chk("restart_pc", fi.id_pc_o, 32'h0);

    // Stall 3 cycles with PC 4 in flight.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0);
      chk("stall3_pc", fi.id_pc_o, 32'h0);
    end
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("release0_pc", fi.id_pc_o, 32'h4);
    chk("release0_valid", 32'(fi.id_valid_o), 32'd1);
    cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk("release1_pc", fi.id_pc_o, 32'h8);
    chk("release1_valid", 32'(fi.id_valid_o), 32'd1);

    // Random stall/redirect traffic.
    for (int i = 0; i < 800; i++) begin
      r_st  = ($urandom_range(0, 99) < 25);
      r_rd  = ($urandom_range(0, 99) < 6);
      r_tgt = 32'($urandom_range(0, 4095));
      cycle(r_st, r_rd, r_tgt, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
